mgc_axi_reg_slice: RTL and testbench
====================================

Name: mgc_axi_reg_slice

Overview:
- Parametrised AXI register slice with five independent channel slices (AW, W, AR forward; B, R reverse), each placed between an upstream and downstream AXI port.
- Each channel is configured as bypass, forward-registered, or fully registered (2-entry skid), to break timing paths on long interconnect routes.
- Address, data, ID, user and burst-length widths are generic. Each channel is carried as one packed payload vector, so the block is protocol-transparent.

Parameters:
ADDR_WIDTH, 64, AxADDR width
DATA_WIDTH, 128, RDATA/WDATA width; legal values 8..1024, power of 2
ID_WIDTH, 8, AxID/WID/BID/RID width
USER_WIDTH, 8, AxUSER/WUSER/BUSER/RUSER width
LEN_WIDTH, 8, AxLEN width; legal values 4, 8 or 10
AW_MODE, 1, AW slice mode: 0 bypass, 1 full skid, 2 forward-only
W_MODE, 1, W slice mode (same encoding)
AR_MODE, 1, AR slice mode (same encoding)
B_MODE, 2, B slice mode (same encoding)
R_MODE, 1, R slice mode (same encoding)

Derived payload widths:
- AW_PW = AR_PW = ID_WIDTH+ADDR_WIDTH+LEN_WIDTH+14+USER_WIDTH (size 3, burst 2, lock 2, cache 4, prot 3)
- W_PW = DATA_WIDTH+DATA_WIDTH/8+ID_WIDTH+1+USER_WIDTH
- B_PW = ID_WIDTH+2+USER_WIDTH
- R_PW = ID_WIDTH+DATA_WIDTH+2+1+USER_WIDTH

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
s_aw_valid, s_w_valid, s_ar_valid  in  1 each  upstream valid, forward channels
s_aw_ready, s_w_ready, s_ar_ready  out  1 each  upstream ready, forward channels
s_aw_payload, s_w_payload, s_ar_payload  in  AW_PW/W_PW/AR_PW  upstream payload
m_aw_valid, m_w_valid, m_ar_valid  out  1 each  downstream valid
m_aw_ready, m_w_ready, m_ar_ready  in  1 each  downstream ready
m_aw_payload, m_w_payload, m_ar_payload  out  AW_PW/W_PW/AR_PW  downstream payload
m_b_valid, m_r_valid  in  1 each  downstream-side valid, reverse channels
m_b_ready, m_r_ready  out  1 each  downstream-side ready, reverse channels
m_b_payload, m_r_payload  in  B_PW/R_PW  downstream-side payload
s_b_valid, s_r_valid  out  1 each  upstream-side valid
s_b_ready, s_r_ready  in  1 each  upstream-side ready
s_b_payload, s_r_payload  out  B_PW/R_PW  upstream-side payload

Behaviour:
- Clocking/reset: one clock, ACLK. Reset ARESET is asynchronous and active-high.
- Channel terms: each channel has in_valid/in_ready/in_payload and out_valid/out_ready/out_payload. Push = in_valid&in_ready; pop = out_valid&out_ready.
- Handshake rules: out_payload stays stable while out_valid&!out_ready. No beat is dropped, duplicated or reordered.
- Mode 0 (bypass): out = in, ready passes backwards combinationally, zero latency, no state.
- Mode 2 (forward-only), single entry:
  - out_valid is registered.
  - in_ready = !out_valid | out_ready (combinational).
  - Latency 1 cycle; throughput 1 beat/cycle.
- Mode 1 (full skid): states EMPTY, ONE, FULL. Main register drives out; skid register holds the overflow beat.
  - in_ready registered: 1 in EMPTY/ONE, 0 in FULL. out_valid registered: 1 in ONE/FULL.
  - EMPTY: push -> ONE (main<=in).
  - ONE: push&!pop -> FULL (skid<=in). pop&!push -> EMPTY. push&pop -> ONE (main<=in).
  - FULL: pop -> ONE (main<=skid). No pop -> FULL. No push is possible in FULL.
  - Latency 1 cycle; sustained 1 beat/cycle with out_ready held high. No combinational path between any in_* and out_* signal.
- Reset values (ARESET high):
  - All out_valid = 0; all payload registers = 0; state = EMPTY.
  - Mode-1 in_ready = 0 while reset is asserted, and 1 from the first ACLK rising edge after deassertion.
- Reset mid-operation: buffered beats are discarded and out_valid drops asynchronously. Upstream must reissue; no partial W bursts are tracked.
- Channels are fully independent; there is no cross-channel ordering (W may lead AW).
- Illegal parameter values (a mode not in {0,1,2}, or an illegal LEN_WIDTH) trigger an elaboration-time $fatal.

Optional Feature:
- Macro: MGC_AXI_REG_SLICE_PERF_EN.
- When defined:
  - Adds ports perf_clr (in, 1) and perf_stall_cnt (out, 160).
  - perf_stall_cnt holds five 32-bit saturating counters: [31:0]=AW, [63:32]=W, [95:64]=AR, [127:96]=B, [159:128]=R.
  - Each counter increments on cycles where out_valid&!out_ready and saturates at 0xFFFFFFFF.
  - perf_clr (synchronous) zeroes all counters and takes priority over increment.
  - ARESET also zeroes all counters.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- AW mode 1, s_aw_valid held high with payloads 1,2,3,4, m_aw_ready=1 -> m_aw_valid first high 1 cycle after the first push; 4 beats on 4 consecutive cycles, in order 1..4.
- W mode 1, 3 beats A,B,C pushed while m_w_ready=0 -> s_w_ready low after 2 pushes, C stalls. Raise ready -> A,B,C delivered in order, C accepted the cycle after FULL->ONE.
- B mode 2, m_b_valid=1 and s_b_ready toggling 1,0,1,0 -> m_b_ready follows !s_b_valid|s_b_ready each cycle; the stalled payload is held stable.
- R mode 0 -> s_r_* equal to m_r_* in the same cycle for 16 random beats; no added latency.
- AR mode 1 FULL with 2 beats, ARESET pulsed mid-stall -> m_ar_valid=0 immediately; s_ar_ready=0 during reset and 1 on the first edge after release; no stale beat emitted.
- With MGC_AXI_REG_SLICE_PERF_EN, AW stalled 5 cycles then perf_clr pulsed -> perf_stall_cnt[31:0]=5, then 0 on the cycle after perf_clr.

Source files
------------

// File: rtl/mgc_axi_reg_slice.sv
// AXI register slice: five independent channel slices (AW, W, AR forward; B, R reverse).
// Latency per channel: 0 (mode 0 bypass), 1 (mode 1 full skid, mode 2 forward-only).
// Backpressure: ready propagates combinationally in modes 0/2, registered (2-entry skid) in mode 1.
// Optional macro MGC_AXI_REG_SLICE_PERF_EN adds per-channel saturating stall counters.

module mgc_axi_reg_slice_chan #(
  parameter int PW   = 8,
  parameter int MODE = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [PW-1:0] in_payload_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [PW-1:0] out_payload_o
);

  if (MODE == 0) begin : g_bypass
    // Pure wires: the slice is transparent, clock and reset are not needed.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign out_valid_o    = in_valid_i;
    assign out_payload_o  = in_payload_i;
    assign in_ready_o     = out_ready_i;

  end else if (MODE == 2) begin : g_fwd
    logic          vld_q;
    logic [PW-1:0] data_q;

    // Accept whenever the single stage is empty or draining this cycle.
    assign in_ready_o    = !vld_q || out_ready_i;
    assign out_valid_o   = vld_q;
    assign out_payload_o = data_q;

    // Single output stage: load on push, clear valid on a pop without refill.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_q  <= 1'b0;
        data_q <= '0;
      end else if (in_valid_i && in_ready_o) begin
        vld_q  <= 1'b1;
        data_q <= in_payload_i;
      end else if (out_ready_i) begin
        vld_q  <= 1'b0;
      end
    end

  end else if (MODE == 1) begin : g_skid
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          rdy_q, vld_q;
    logic          push, pop;

    // Both handshake outputs come straight from flops: no in->out comb path.
    assign in_ready_o    = rdy_q;
    assign out_valid_o   = vld_q;
    assign out_payload_o = main_q;
    assign push          = in_valid_i && rdy_q;
    assign pop           = vld_q && out_ready_i;

    // Occupancy transitions; main always holds the oldest beat.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = in_payload_i;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            skid_d  = in_payload_i;
            state_d = ST_FULL;
          end else if (pop && !push) begin
            state_d = ST_EMPTY;
          end else if (push && pop) begin
            main_d  = in_payload_i;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // State, data and registered handshake flags; ready stays low in reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        rdy_q   <= 1'b0;
        vld_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        rdy_q   <= (state_d != ST_FULL);
        vld_q   <= (state_d != ST_EMPTY);
      end
    end

  end else begin : g_bad_mode
    $fatal(1, "mgc_axi_reg_slice_chan: MODE %0d is not one of 0, 1, 2", MODE);
  end

endmodule

module mgc_axi_reg_slice #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int AW_MODE    = 1,
  parameter int W_MODE     = 1,
  parameter int AR_MODE    = 1,
  parameter int B_MODE     = 2,
  parameter int R_MODE     = 1,
  localparam int AW_PW = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 14 + USER_WIDTH,
  localparam int AR_PW = AW_PW,
  localparam int W_PW  = DATA_WIDTH + DATA_WIDTH / 8 + ID_WIDTH + 1 + USER_WIDTH,
  localparam int B_PW  = ID_WIDTH + 2 + USER_WIDTH,
  localparam int R_PW  = ID_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             s_aw_valid,
  output logic             s_aw_ready,
  input  logic [AW_PW-1:0] s_aw_payload,
  input  logic             s_w_valid,
  output logic             s_w_ready,
  input  logic [W_PW-1:0]  s_w_payload,
  input  logic             s_ar_valid,
  output logic             s_ar_ready,
  input  logic [AR_PW-1:0] s_ar_payload,
  output logic             m_aw_valid,
  input  logic             m_aw_ready,
  output logic [AW_PW-1:0] m_aw_payload,
  output logic             m_w_valid,
  input  logic             m_w_ready,
  output logic [W_PW-1:0]  m_w_payload,
  output logic             m_ar_valid,
  input  logic             m_ar_ready,
  output logic [AR_PW-1:0] m_ar_payload,
  input  logic             m_b_valid,
  output logic             m_b_ready,
  input  logic [B_PW-1:0]  m_b_payload,
  input  logic             m_r_valid,
  output logic             m_r_ready,
  input  logic [R_PW-1:0]  m_r_payload,
  output logic             s_b_valid,
  input  logic             s_b_ready,
  output logic [B_PW-1:0]  s_b_payload,
  output logic             s_r_valid,
  input  logic             s_r_ready,
  output logic [R_PW-1:0]  s_r_payload
`ifdef MGC_AXI_REG_SLICE_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [159:0]     perf_stall_cnt
`endif
);

  if (!(LEN_WIDTH == 4 || LEN_WIDTH == 8 || LEN_WIDTH == 10)) begin : g_bad_len
    $fatal(1, "mgc_axi_reg_slice: LEN_WIDTH %0d must be 4, 8 or 10", LEN_WIDTH);
  end
  if (DATA_WIDTH < 8 || DATA_WIDTH > 1024 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_dw
    $fatal(1, "mgc_axi_reg_slice: DATA_WIDTH %0d must be a power of 2 in 8..1024", DATA_WIDTH);
  end

  mgc_axi_reg_slice_chan #(.PW(AW_PW), .MODE(AW_MODE)) u_aw (
    .clk_i(ACLK), .rst_i(ARESET),
    .in_valid_i(s_aw_valid), .in_ready_o(s_aw_ready), .in_payload_i(s_aw_payload),
    .out_valid_o(m_aw_valid), .out_ready_i(m_aw_ready), .out_payload_o(m_aw_payload)
  );

  mgc_axi_reg_slice_chan #(.PW(W_PW), .MODE(W_MODE)) u_w (
    .clk_i(ACLK), .rst_i(ARESET),
    .in_valid_i(s_w_valid), .in_ready_o(s_w_ready), .in_payload_i(s_w_payload),
    .out_valid_o(m_w_valid), .out_ready_i(m_w_ready), .out_payload_o(m_w_payload)
  );

  mgc_axi_reg_slice_chan #(.PW(AR_PW), .MODE(AR_MODE)) u_ar (
    .clk_i(ACLK), .rst_i(ARESET),
    .in_valid_i(s_ar_valid), .in_ready_o(s_ar_ready), .in_payload_i(s_ar_payload),
    .out_valid_o(m_ar_valid), .out_ready_i(m_ar_ready), .out_payload_o(m_ar_payload)
  );

  // Reverse channels: the downstream (m_) side is the slice input.
  mgc_axi_reg_slice_chan #(.PW(B_PW), .MODE(B_MODE)) u_b (
    .clk_i(ACLK), .rst_i(ARESET),
    .in_valid_i(m_b_valid), .in_ready_o(m_b_ready), .in_payload_i(m_b_payload),
    .out_valid_o(s_b_valid), .out_ready_i(s_b_ready), .out_payload_o(s_b_payload)
  );

  mgc_axi_reg_slice_chan #(.PW(R_PW), .MODE(R_MODE)) u_r (
    .clk_i(ACLK), .rst_i(ARESET),
    .in_valid_i(m_r_valid), .in_ready_o(m_r_ready), .in_payload_i(m_r_payload),
    .out_valid_o(s_r_valid), .out_ready_i(s_r_ready), .out_payload_o(s_r_payload)
  );

`ifdef MGC_AXI_REG_SLICE_PERF_EN
  logic [4:0] stall;
  assign stall = {s_r_valid  && !s_r_ready,
                  s_b_valid  && !s_b_ready,
                  m_ar_valid && !m_ar_ready,
                  m_w_valid  && !m_w_ready,
                  m_aw_valid && !m_aw_ready};

  for (genvar i = 0; i < 5; i++) begin : g_perf
    logic [31:0] cnt_q;
    // Saturating stall counter; a synchronous clear beats an increment.
    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        cnt_q <= '0;
      end else if (perf_clr) begin
        cnt_q <= '0;
      end else if (stall[i] && cnt_q != 32'hFFFF_FFFF) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign perf_stall_cnt[i*32 +: 32] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_mgc_axi_reg_slice.sv
// Bench for mgc_axi_reg_slice: AW/W/AR full skid, B forward-only, R bypass.
// A per-channel occupancy model is checked every falling edge; directed literals pin it.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.

module tb_mgc_axi_reg_slice;
  localparam int AW = 16, DW = 32, IW = 4, UW = 2, LW = 8;
  localparam int AX_PW = IW + AW + LW + 14 + UW;
  localparam int W_PW  = DW + DW / 8 + IW + 1 + UW;
  localparam int B_PW  = IW + 2 + UW;
  localparam int R_PW  = IW + DW + 3 + UW;

  logic ACLK = 1'b0;
  logic ARESET = 1'b0;
  logic s_aw_valid = 0, s_w_valid = 0, s_ar_valid = 0;
  logic s_aw_ready, s_w_ready, s_ar_ready;
  logic [AX_PW-1:0] s_aw_payload = '0, s_ar_payload = '0;
  logic [W_PW-1:0]  s_w_payload = '0;
  logic m_aw_valid, m_w_valid, m_ar_valid;
  logic m_aw_ready = 0, m_w_ready = 0, m_ar_ready = 0;
  logic [AX_PW-1:0] m_aw_payload, m_ar_payload;
  logic [W_PW-1:0]  m_w_payload;
  logic m_b_valid = 0, m_r_valid = 0;
  logic m_b_ready, m_r_ready;
  logic [B_PW-1:0] m_b_payload = '0;
  logic [R_PW-1:0] m_r_payload = '0;
  logic s_b_valid, s_r_valid;
  logic s_b_ready = 0, s_r_ready = 0;
  logic [B_PW-1:0] s_b_payload;
  logic [R_PW-1:0] s_r_payload;
`ifdef MGC_AXI_REG_SLICE_PERF_EN
  logic perf_clr = 1'b0;
  logic [159:0] perf_stall_cnt;
`endif

  always #5 ACLK = ~ACLK;

  mgc_axi_reg_slice #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .LEN_WIDTH(LW),
    .AW_MODE(1), .W_MODE(1), .AR_MODE(1), .B_MODE(2), .R_MODE(0)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_payload(s_aw_payload),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_payload(s_w_payload),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_payload(s_ar_payload),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_payload(m_aw_payload),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_payload(m_w_payload),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_payload(m_ar_payload),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_payload(m_b_payload),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_payload(m_r_payload),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_payload(s_b_payload),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_payload(s_r_payload)
`ifdef MGC_AXI_REG_SLICE_PERF_EN
    ,
    .perf_clr(perf_clr), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Channel order: 0 AW, 1 W, 2 AR, 3 B, 4 R.
  function automatic int mode_of(input int c);
    case (c)
      3:       return 2;
      4:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic string name_of(input int c);
    case (c)
      0: return "aw";
      1: return "w";
      2: return "ar";
      3: return "b";
      default: return "r";
    endcase
  endfunction

  // Model: each registered channel is an in-order buffer of capacity 2 (skid) or 1 (forward).
  logic [63:0] mdat [5][2];
  int          mcnt [5];
  bit          rdy_ok = 1'b0;

  initial begin
    for (int c = 0; c < 5; c++) mcnt[c] = 0;
  end

  always @(negedge ACLK) begin
    logic [4:0]  iv, ordy, irdy, ov;
    logic [63:0] ip [5];
    logic [63:0] op [5];
    logic        ev, er, push, pop;
    logic [63:0] ep;
    int          md;
    iv   = {m_r_valid, m_b_valid, s_ar_valid, s_w_valid, s_aw_valid};
    ordy = {s_r_ready, s_b_ready, m_ar_ready, m_w_ready, m_aw_ready};
    irdy = {m_r_ready, m_b_ready, s_ar_ready, s_w_ready, s_aw_ready};
    ov   = {s_r_valid, s_b_valid, m_ar_valid, m_w_valid, m_aw_valid};
    ip[0] = 64'(s_aw_payload); op[0] = 64'(m_aw_payload);
    ip[1] = 64'(s_w_payload);  op[1] = 64'(m_w_payload);
    ip[2] = 64'(s_ar_payload); op[2] = 64'(m_ar_payload);
    ip[3] = 64'(m_b_payload);  op[3] = 64'(s_b_payload);
    ip[4] = 64'(m_r_payload);  op[4] = 64'(s_r_payload);
    for (int c = 0; c < 5; c++) begin
      md = mode_of(c);
      if (ARESET) mcnt[c] = 0;
      if (md == 0) begin
        ev = iv[c];
        er = ordy[c];
        ep = ip[c];
      end else begin
        ev = (mcnt[c] > 0);
        ep = mdat[c][0];
        if (md == 1) er = !ARESET && rdy_ok && (mcnt[c] < 2);
        else         er = (mcnt[c] == 0) || ordy[c];
      end
      chk({"model ", name_of(c), " out_valid"}, 64'(ov[c]), 64'(ev));
      chk({"model ", name_of(c), " in_ready"}, 64'(irdy[c]), 64'(er));
      if (ev) chk({"model ", name_of(c), " out_payload"}, op[c], ep);
      if (!ARESET && md != 0) begin
        push = iv[c] && er;
        pop  = ev && ordy[c];
        if (pop) begin
          mdat[c][0] = mdat[c][1];
          mcnt[c]    = mcnt[c] - 1;
        end
        if (push) begin
          mdat[c][mcnt[c]] = ip[c];
          mcnt[c]          = mcnt[c] + 1;
        end
      end
    end
    rdy_ok = !ARESET;
  end

  initial begin
    logic [63:0] rnd;
    logic        rv, rr;
    logic [R_PW-1:0] rp;

    // Reset state.
    #1 ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst m_aw_valid", 64'(m_aw_valid), 64'd0);
    chk("rst s_aw_ready", 64'(s_aw_ready), 64'd0);
    chk("rst m_w_valid", 64'(m_w_valid), 64'd0);
    chk("rst m_ar_valid", 64'(m_ar_valid), 64'd0);
    chk("rst s_b_valid", 64'(s_b_valid), 64'd0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("release s_aw_ready before edge", 64'(s_aw_ready), 64'd0);
    @(posedge ACLK); #1;
    chk("release s_aw_ready after edge", 64'(s_aw_ready), 64'd1);

    // AW full skid streaming 1..4 with downstream always ready.
    m_aw_ready = 1; s_aw_valid = 1; s_aw_payload = AX_PW'(1);
    @(negedge ACLK);
    chk("aw latency", 64'(m_aw_valid), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge ACLK); #1;
      if (k < 4) s_aw_payload = AX_PW'(k + 1);
      else       s_aw_valid = 0;
      @(negedge ACLK);
      chk("aw beat valid", 64'(m_aw_valid), 64'd1);
      chk("aw beat data", 64'(m_aw_payload), 64'(k));
    end
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("aw drained", 64'(m_aw_valid), 64'd0);

    // W fills to FULL, third beat stalls, then drains in order.
    @(posedge ACLK); #1 m_w_ready = 0; s_w_valid = 1; s_w_payload = W_PW'('hA);
    @(posedge ACLK); #1 s_w_payload = W_PW'('hB);
    @(posedge ACLK); #1 s_w_payload = W_PW'('hC);
    @(negedge ACLK);
    chk("w full ready", 64'(s_w_ready), 64'd0);
    chk("w full head", 64'(m_w_payload), 64'hA);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("w C stalled", 64'(s_w_ready), 64'd0);
    @(posedge ACLK); #1 m_w_ready = 1;
    @(negedge ACLK);
    chk("w still full", 64'(s_w_ready), 64'd0);
    chk("w head A", 64'(m_w_payload), 64'hA);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("w ready after FULL->ONE", 64'(s_w_ready), 64'd1);
    chk("w head B", 64'(m_w_payload), 64'hB);
    @(posedge ACLK); #1 s_w_valid = 0;
    @(negedge ACLK);
    chk("w head C", 64'(m_w_payload), 64'hC);
    chk("w C valid", 64'(m_w_valid), 64'd1);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("w drained", 64'(m_w_valid), 64'd0);

    // B forward-only with s_b_ready toggling.
    @(posedge ACLK); #1 m_b_valid = 1; m_b_payload = B_PW'('h11); s_b_ready = 1;
    @(negedge ACLK);
    chk("b ready empty", 64'(m_b_ready), 64'd1);
    @(posedge ACLK); #1 m_b_payload = B_PW'('h22); s_b_ready = 0;
    @(negedge ACLK);
    chk("b out 11", 64'(s_b_payload), 64'h11);
    chk("b ready stalled", 64'(m_b_ready), 64'd0);
    @(posedge ACLK); #1 s_b_ready = 1;
    @(negedge ACLK);
    chk("b 11 held", 64'(s_b_payload), 64'h11);
    chk("b ready pass", 64'(m_b_ready), 64'd1);
    @(posedge ACLK); #1 m_b_payload = B_PW'('h33); s_b_ready = 0;
    @(negedge ACLK);
    chk("b out 22", 64'(s_b_payload), 64'h22);
    chk("b ready stalled 2", 64'(m_b_ready), 64'd0);
    @(posedge ACLK); #1 s_b_ready = 1;
    @(negedge ACLK);
    chk("b 22 held", 64'(s_b_payload), 64'h22);
    @(posedge ACLK); #1 m_b_valid = 0;
    @(negedge ACLK);
    chk("b out 33", 64'(s_b_payload), 64'h33);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("b drained", 64'(s_b_valid), 64'd0);

    // R bypass: same-cycle pass-through of random beats.
    for (int i = 0; i < 16; i++) begin
      @(posedge ACLK); #1;
      rnd = {$urandom, $urandom};
      rv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rp = rnd[R_PW-1:0];
      m_r_valid = rv; m_r_payload = rp; s_r_ready = rr;
      @(negedge ACLK);
      chk("r bypass valid", 64'(s_r_valid), 64'(rv));
      chk("r bypass payload", 64'(s_r_payload), 64'(rp));
      chk("r bypass ready", 64'(m_r_ready), 64'(rr));
    end
    @(posedge ACLK); #1 m_r_valid = 0;

    // AR filled then reset mid-stall.
    @(posedge ACLK); #1 m_ar_ready = 0; s_ar_valid = 1; s_ar_payload = AX_PW'(1);
    @(posedge ACLK); #1 s_ar_payload = AX_PW'(2);
    @(posedge ACLK); #1 s_ar_valid = 0;
    @(negedge ACLK);
    chk("ar full valid", 64'(m_ar_valid), 64'd1);
    chk("ar full ready", 64'(s_ar_ready), 64'd0);
    chk("ar full head", 64'(m_ar_payload), 64'd1);
    @(posedge ACLK); #1 ARESET = 1'b1;
    #1;
    chk("ar reset valid async", 64'(m_ar_valid), 64'd0);
    chk("ar reset ready", 64'(s_ar_ready), 64'd0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("ar ready before edge", 64'(s_ar_ready), 64'd0);
    @(posedge ACLK); #1;
    chk("ar ready after edge", 64'(s_ar_ready), 64'd1);
    m_ar_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("ar no stale beat", 64'(m_ar_valid), 64'd0);
    end

`ifdef MGC_AXI_REG_SLICE_PERF_EN
    // AW stall counter: 5 stalled edges, then clear.
    @(posedge ACLK); #1 perf_clr = 1; m_aw_ready = 0; s_aw_valid = 1; s_aw_payload = AX_PW'(7);
    @(posedge ACLK); #1 perf_clr = 0; s_aw_valid = 0;
    repeat (5) @(posedge ACLK);
    #1;
    chk("perf aw count", 64'(perf_stall_cnt[31:0]), 64'd5);
    chk("perf w count", 64'(perf_stall_cnt[63:32]), 64'd0);
    perf_clr = 1;
    @(posedge ACLK); #1;
    chk("perf aw cleared", 64'(perf_stall_cnt[31:0]), 64'd0);
    perf_clr = 0; m_aw_ready = 1;
`endif

    repeat (3) @(posedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
